// File: rtl/sdram_port_arbiter_if.sv
// Controller-side request/ack bundle between the port arbiter and the SDRAM core.
// master = arbiter (drives the muxed request), slave = controller.
interface sdram_port_arbiter_if #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 16
) ();
    logic                   acc_o;
    logic [ADR_WIDTH-1:0]   adr_o;
    logic [DAT_WIDTH-1:0]   dat_o;
    logic [DAT_WIDTH/8-1:0] sel_o;
    logic                   we_o;
    logic                   ack_i;
    logic                   sdram_idle_i;

    modport master (
        output acc_o, adr_o, dat_o, sel_o, we_o,
        input  ack_i, sdram_idle_i
    );

    modport slave (
        input  acc_o, adr_o, dat_o, sel_o, we_o,
        output ack_i, sdram_idle_i
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin N-port arbiter in front of the SDRAM controller core.
// Define SDRAM_ARB_PRIO_EN to give port 0 fixed priority and exempt it from MAX_BEATS.
module sdram_port_arbiter #(
    parameter int PORTS     = 3,
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic                           sdram_clk,
    input  logic                           sdram_rst_n,
    input  logic [PORTS-1:0]               p_acc_i,
    input  logic [PORTS*ADR_WIDTH-1:0]     p_adr_i,
    input  logic [PORTS*DAT_WIDTH-1:0]     p_dat_i,
    input  logic [PORTS*DAT_WIDTH/8-1:0]   p_sel_i,
    input  logic [PORTS-1:0]               p_we_i,
    output logic [PORTS-1:0]               p_ack_o,
    output logic [PORTS-1:0]               grant_o,
    output logic [$clog2(PORTS)-1:0]       grant_enc_o,
    sdram_port_arbiter_if.master           ctl
);
    localparam int EW = $clog2(PORTS);
    localparam int SW = DAT_WIDTH / 8;
    localparam int BW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);
    localparam logic [EW-1:0] LAST_RST = EW'(PORTS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [EW-1:0]    enc_q, enc_d;
    logic [EW-1:0]    last_q, last_d;
    logic [BW-1:0]    beats_q, beats_d;

    logic [PORTS-1:0] elig;
    logic [EW-1:0]    idx;
    logic [EW-1:0]    rr_win, win;
    logic             rr_vld, win_vld;
    logic             held, arb_en, force_sw, prio_exempt;

    logic [ADR_WIDTH-1:0] adr_a [PORTS];
    logic [DAT_WIDTH-1:0] dat_a [PORTS];
    logic [SW-1:0]        sel_a [PORTS];

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign adr_a[i] = p_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
        assign dat_a[i] = p_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
        assign sel_a[i] = p_sel_i[i*SW +: SW];
    end

`ifdef SDRAM_ARB_PRIO_EN
    assign elig        = p_acc_i & ~PORTS'(1);
    assign prio_exempt = (enc_q == '0);
`else
    assign elig        = p_acc_i;
    assign prio_exempt = 1'b0;
`endif

    // Scan last+PORTS down to last+1 so the nearest requester overwrites the rest.
    always_comb begin
        rr_win = '0;
        rr_vld = 1'b0;
        idx    = '0;
        for (int k = PORTS; k >= 1; k--) begin
            idx = EW'((int'(last_q) + k) % PORTS);
            if (elig[idx]) begin
                rr_win = idx;
                rr_vld = 1'b1;
            end
        end
        win     = rr_win;
        win_vld = rr_vld;
`ifdef SDRAM_ARB_PRIO_EN
        if (p_acc_i[0]) begin
            win     = '0;
            win_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        enc_d    = enc_q;
        last_d   = last_q;
        beats_d  = beats_q;
        force_sw = 1'b0;
        arb_en   = 1'b0;
        unique case (state_q)
            S_GRANT: begin
                if (ctl.ack_i && beats_q != BEAT_MAX)
                    beats_d = beats_q + 1'b1;
                force_sw = (MAX_BEATS != 0) && (beats_d == BEAT_MAX)
                         && (|(p_acc_i & ~grant_q)) && !prio_exempt;
                if (!p_acc_i[enc_q] || force_sw)
                    state_d = S_DRAIN;
            end
            S_IDLE, S_DRAIN: arb_en = ctl.sdram_idle_i;
            default: state_d = S_IDLE;
        endcase
        if (arb_en) begin
            if (win_vld) begin
                state_d = S_GRANT;
                grant_d = PORTS'(1) << win;
                enc_d   = win;
                last_d  = win;
                beats_d = '0;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                enc_d   = '0;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            enc_q   <= '0;
            last_q  <= LAST_RST;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            enc_q   <= enc_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // Late acks in DRAIN still belong to the held port.
    assign held        = (state_q == S_GRANT) || (state_q == S_DRAIN);
    assign ctl.acc_o   = (state_q == S_GRANT) && p_acc_i[enc_q];
    assign ctl.adr_o   = adr_a[enc_q];
    assign ctl.dat_o   = dat_a[enc_q];
    assign ctl.sel_o   = sel_a[enc_q];
    assign ctl.we_o    = held && p_we_i[enc_q];
    assign p_ack_o     = (held && ctl.ack_i) ? grant_q : '0;
    assign grant_o     = grant_q;
    assign grant_enc_o = enc_q;

endmodule
